// File: rtl/apb_master_ctrl_if.sv
// Bundle of the command stream, response stream and APB3 bus signals
// around apb_master_ctrl. The master modport is the controller's view.
interface apb_master_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    // command stream
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    // response stream
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;

    // APB3 bus
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  pready, prdata, pslverr,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output pready, prdata, pslverr,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  paddr, psel, penable, pwrite, pwdata
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB3 master: accepts one command, runs SETUP/ACCESS on
// the bus, and returns read data and status. Stalled ACCESS phases are
// aborted after TIMEOUT wait cycles. All outputs are registers.
module apb_master_ctrl #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 16
) (
    input logic               pclk,
    input logic               presetn,
    apb_master_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    // last wait-counter value allowed before the transfer is abandoned
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t        state;
    logic [7:0]    wait_cnt;
    logic          cmd_ready_r;
    logic          psel_r;
    logic          penable_r;
    logic          pwrite_r;
    logic [AW-1:0] paddr_r;
    logic [DW-1:0] pwdata_r;
    logic          rsp_valid_r;
    logic [DW-1:0] rsp_rdata_r;
    logic          rsp_err_r;
    logic          rsp_timeout_r;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Transfer sequencer: next state and every registered output together
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            cmd_ready_r   <= 1'b0;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= '0;
            pwdata_r      <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_r) begin
                        paddr_r     <= bus.cmd_addr;
                        pwrite_r    <= bus.cmd_write;
                        pwdata_r    <= bus.cmd_wdata;
                        cmd_ready_r <= 1'b0;
                        psel_r      <= 1'b1;
                        state       <= SETUP;
                    end else begin
                        // first cycle out of reset raises ready here
                        cmd_ready_r <= 1'b1;
                    end
                end
                SETUP: begin
                    wait_cnt  <= '0;
                    penable_r <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // a completing pready wins over a timeout in the same cycle
                    if (bus.pready) begin
                        rsp_rdata_r   <= pwrite_r ? '0 : bus.prdata;
                        rsp_err_r     <= bus.pslverr;
                        rsp_timeout_r <= 1'b0;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        state         <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rsp_rdata_r   <= '0;
                        rsp_err_r     <= 1'b1;
                        rsp_timeout_r <= 1'b1;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= sat_inc(wait_cnt);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_r;
    assign bus.psel        = psel_r;
    assign bus.penable     = penable_r;
    assign bus.pwrite      = pwrite_r;
    assign bus.paddr       = paddr_r;
    assign bus.pwdata      = pwdata_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rsp_rdata_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.rsp_timeout = rsp_timeout_r;
endmodule
